axi_sram_slave: RTL and testbench
=================================

Name:
axi_sram_slave

Overview:
Parametrised AXI4 slave with an internal word-addressed memory, the next generation of SRAM_wrapper: configurable data/address/ID/length widths, FIXED/INCR/WRAP bursts, byte strobes, alternating read/write arbitration and SLVERR reporting. It sits behind the bus interconnect as a memory slave and is verified standalone against the AXI master VIP.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of two, >=8); STRB_WIDTH = DATA_WIDTH/8; OFS = log2(STRB_WIDTH)
ADDR_WIDTH, 16, byte address width
ID_WIDTH, 8, transaction ID width (slave-side, interconnect-extended)
LEN_WIDTH, 4, burst length field width; beats = LEN+1
MEM_WORDS, 2**(ADDR_WIDTH-OFS), memory depth in words; word index = ADDR[ADDR_WIDTH-1:OFS] modulo MEM_WORDS

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
ARID  in  ID_WIDTH  read ID
ARADDR  in  ADDR_WIDTH  read start byte address (low OFS bits ignored)
ARLEN  in  LEN_WIDTH  read beats minus one
ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RID  out  ID_WIDTH  latched ARID
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  final read beat
RVALID  out  1  read data valid
RREADY  in  1  read data ready
AWID  in  ID_WIDTH  write ID
AWADDR  in  ADDR_WIDTH  write start byte address
AWLEN  in  LEN_WIDTH  write beats minus one
AWBURST  in  2  encoding as ARBURST
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  STRB_WIDTH  byte-lane enables
WLAST  in  1  final write beat
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BID  out  ID_WIDTH  latched AWID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready

Behaviour:
- Reset (reset=0, async): FSM->IDLE, priority bit->write-first; ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID=0; RDATA, RID, BID, RRESP, BRESP=0. Memory contents not reset. Reset mid-burst aborts it; beats already written stay written.
- FSM: IDLE, RD, WR_DATA, WR_RESP. One transaction at a time; no outstanding queue.
- IDLE grant (combinational on valids): only AWVALID -> AWREADY=1; only ARVALID -> ARREADY=1; both -> grant the side indicated by priority bit, which toggles after every grant made with both valid. Never ARREADY and AWREADY together. AR handshake -> RD; AW handshake -> WR_DATA. ID, address, LEN, BURST latched at handshake.
- RD: RVALID rises the cycle after the AR handshake (1-cycle memory latency). Next word is prefetched at each R handshake so RVALID stays high back-to-back with RREADY=1. RDATA/RID/RRESP/RLAST held stable while RVALID=1 and RREADY=0. RLAST=1 on beat LEN+1 only. Handshake on RLAST -> IDLE (RVALID=0 next cycle).
- WR_DATA: WREADY=1; each W handshake writes byte lanes with WSTRB=1 to the current word. Handshake with WLAST=1 -> WR_RESP. Burst ends at WLAST; if WLAST beat number != LEN+1, or WLAST absent on beat LEN+1 (further beats are still accepted and discarded), BRESP=10.
- WR_RESP: BVALID=1 with BID, BRESP held until BREADY; handshake -> IDLE.
- Address advance per beat (word index): FIXED unchanged; INCR +1 modulo MEM_WORDS; WRAP: mask=LEN, next = (idx & ~mask) | ((idx+1) & mask).
- Errors: BURST=11, or WRAP with LEN not in {1,3,7,15}: reads return RDATA=0, RRESP=10 on every beat with correct beat count and RLAST; writes perform no memory update, BRESP=10. Otherwise responses are 00.

Test Plan:
- INCR write AWLEN=3 at 0x0010 with A0,A1,A2,A3, WSTRB=F; INCR read ARLEN=3 at 0x0010 -> RDATA A0..A3, RLAST only on beat 4, RRESP=00, RID=ARID, BRESP=00, BID=AWID.
- WRAP write AWLEN=3 at 0x0018 with D0..D3 -> words 6,7,4,5 hold D0..D3; WRAP read at 0x0018 -> D0,D1,D2,D3; WRAP with LEN=2 -> RRESP=10 on all 3 beats.
- Word 0xAABBCCDD, write 0x11223344 with WSTRB=0101 -> read returns 0xAA22CC44; FIXED write of 4 beats at 0x0000 -> only last beat value remains.
- After reset, AWVALID and ARVALID asserted together twice -> write, read, then read, write order; ARREADY and AWREADY never high together.
- RREADY held low 3 cycles on beat 2 -> RDATA, RLAST unchanged; WLAST on beat 2 of AWLEN=3 -> BRESP=10; AWBURST=11 -> memory unchanged, BRESP=10.
- reset pulled low mid-read burst -> RVALID=0 asynchronously, no further beats; after release a new AR is accepted from IDLE with RVALID rising one cycle later.

Source files
------------

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI4 memory slave backed by an internal word-addressed array. It handles one
// transaction at a time with FIXED, INCR and WRAP bursts and byte strobes, and
// reports SLVERR for reserved or illegal bursts and for WLAST mismatches.
// When AW and AR arrive together in IDLE, the grant alternates between them.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   AR* / R*               read address channel and read data channel
//   AW* / W* / B*          write address, write data and write response
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned MEM_WORDS  = 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))
) (
    input  logic                      clock,
    input  logic                      reset,
    // read address
    input  logic [ID_WIDTH-1:0]       ARID,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic [LEN_WIDTH-1:0]      ARLEN,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    // read data
    output logic [ID_WIDTH-1:0]       RID,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    // write address
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [LEN_WIDTH-1:0]      AWLEN,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    // write data
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [(DATA_WIDTH/8)-1:0] WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    // write response
    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFS        = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W      = ADDR_WIDTH - OFS;
    localparam int unsigned MW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    state_t                r_state;
    logic                  r_prio_wr;
    logic [IDX_W-1:0]      r_idx;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic                  r_werr;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic                  r_rvalid;
    logic                  r_wready;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic                  r_bvalid;

    logic                  w_idle;
    logic                  w_aw_go;
    logic                  w_ar_go;
    logic [IDX_W-1:0]      w_aw_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_err;
    logic                  w_r_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_wr_en;
    logic                  w_beat_last;
    logic [MW-1:0]         w_word;

    // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats
    function automatic logic f_burst_err(input logic [1:0] burst,
                                         input logic [LEN_WIDTH-1:0] len);
        logic legal_wrap;
        legal_wrap = (32'(len) == 32'd1) || (32'(len) == 32'd3) ||
                     (32'(len) == 32'd7) || (32'(len) == 32'd15);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !legal_wrap);
    endfunction

    // Word index of the following beat
    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0]     idx,
                                                input logic [1:0]           burst,
                                                input logic [LEN_WIDTH-1:0] len);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'(len);
        case (burst)
            BURST_INCR: f_next = IDX_W'((32'(idx) + 32'd1) % MEM_WORDS);
            BURST_WRAP: f_next = (idx & ~mask) | ((idx + IDX_W'(1)) & mask);
            default:    f_next = idx;
        endcase
    endfunction

    // Physical memory row for a word index
    function automatic logic [MW-1:0] f_word(input logic [IDX_W-1:0] idx);
        return MW'(32'(idx) % MEM_WORDS);
    endfunction

    // IDLE arbitration: a lone request wins, simultaneous requests follow r_prio_wr
    assign w_idle   = (r_state == S_IDLE);
    assign w_aw_go  = w_idle && AWVALID && (!ARVALID || r_prio_wr);
    assign w_ar_go  = w_idle && ARVALID && (!AWVALID || !r_prio_wr);
    assign w_aw_idx = IDX_W'(AWADDR >> OFS);
    assign w_ar_idx = IDX_W'(ARADDR >> OFS);
    assign w_ar_err = f_burst_err(ARBURST, ARLEN);

    assign w_r_hs      = r_rvalid && RREADY;
    assign w_w_hs      = r_wready && WVALID;
    assign w_b_hs      = r_bvalid && BREADY;
    assign w_beat_last = (r_beat == r_len);
    assign w_word      = f_word(r_idx);
    // Error bursts and beats past LEN+1 never touch memory
    assign w_wr_en     = w_w_hs && !r_err && !r_werr;

    // Control FSM and registered channel outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_prio_wr <= 1'b1;
            r_idx     <= '0;
            r_len     <= '0;
            r_burst   <= BURST_FIXED;
            r_err     <= 1'b0;
            r_beat    <= '0;
            r_werr    <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_wready  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_bvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (AWVALID && ARVALID) begin
                        r_prio_wr <= ~r_prio_wr;
                    end
                    if (w_aw_go) begin
                        r_bid    <= AWID;
                        r_idx    <= w_aw_idx;
                        r_len    <= AWLEN;
                        r_burst  <= AWBURST;
                        r_err    <= f_burst_err(AWBURST, AWLEN);
                        r_beat   <= '0;
                        r_werr   <= 1'b0;
                        r_wready <= 1'b1;
                        r_state  <= S_WR_DATA;
                    end else if (w_ar_go) begin
                        // First word is fetched here so RVALID rises next cycle
                        r_rid    <= ARID;
                        r_len    <= ARLEN;
                        r_burst  <= ARBURST;
                        r_err    <= w_ar_err;
                        r_beat   <= '0;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (ARLEN == '0);
                        r_rresp  <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
                        r_rdata  <= w_ar_err ? '0 : r_mem[f_word(w_ar_idx)];
                        r_idx    <= f_next(w_ar_idx, ARBURST, ARLEN);
                        r_state  <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            // Prefetch the next beat so RVALID stays high
                            r_rdata <= r_err ? '0 : r_mem[w_word];
                            r_idx   <= f_next(r_idx, r_burst, r_len);
                            r_beat  <= r_beat + LEN_WIDTH'(1);
                            r_rlast <= ((r_beat + LEN_WIDTH'(1)) == r_len);
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_w_hs) begin
                        r_idx <= f_next(r_idx, r_burst, r_len);
                        if (!r_werr) begin
                            r_beat <= r_beat + LEN_WIDTH'(1);
                        end
                        if (WLAST) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_err || r_werr || !w_beat_last) ? RESP_SLVERR
                                                                         : RESP_OKAY;
                            r_state  <= S_WR_RESP;
                        end else if (w_beat_last) begin
                            // LEN+1 beats done without WLAST: swallow the rest
                            r_werr <= 1'b1;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Byte-lane memory write; contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (WSTRB[b]) begin
                    r_mem[w_word][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Ready outputs are held low while reset is asserted
    assign AWREADY = w_aw_go && reset;
    assign ARREADY = w_ar_go && reset;
    assign WREADY  = r_wready;
    assign RID     = r_rid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;
    assign RVALID  = r_rvalid;
    assign BID     = r_bid;
    assign BRESP   = r_bresp;
    assign BVALID  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Drives axi_sram_slave with directed and randomized AXI bursts and compares
// every response against a behavioural memory model that computes beat
// addresses directly from the burst rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_sram_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned NW = 16384;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [LW-1:0] ARLEN;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic [IW-1:0] AWID;
    logic [AW-1:0] AWADDR;
    logic [LW-1:0] AWLEN;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;

    axi_sram_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW),
        .MEM_WORDS  (NW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARBURST (ARBURST),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWBURST (AWBURST),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int n_both = 0;

    logic [DW-1:0] m_mem [NW];
    logic [DW-1:0] wdat  [24];
    logic [3:0]    wstb  [24];

    logic [IW-1:0] wr_id;
    int            wr_idx, wr_len, wr_burst;
    logic [IW-1:0] rd_id;
    int            rd_idx, rd_len, rd_burst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit burst_err(input int len, input int burst);
        return (burst == 3) || ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Word touched by beat b: FIXED stays put, INCR walks, WRAP rotates in an aligned block
    function automatic int beat_word(input int start, input int len, input int burst, input int b);
        int n;
        int base;
        if (burst == 0) return start;
        if (burst == 1) return (start + b) % NW;
        n    = len + 1;
        base = start - (start % n);
        return base + ((start - base + b) % n);
    endfunction

    always @(posedge clock) begin
        if (ARREADY && AWREADY) n_both++;
    end

    // Tasks are entered and left right at a falling edge
    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int burst);
        int cnt = 0;
        AWID = id; AWADDR = addr; AWLEN = LW'(len); AWBURST = 2'(burst); AWVALID = 1'b1;
        wr_id = id; wr_idx = int'(addr) >> 2; wr_len = len; wr_burst = burst;
        #1;
        while (!AWREADY && cnt < 50) begin
            @(negedge clock); #1; cnt++;
        end
        if (!AWREADY) check_eq("aw_handshake", 64'(AWREADY), 64'd1);
        @(posedge clock);
        @(negedge clock);
        AWVALID = 1'b0;
    endtask

    task automatic send_w_b(input int nbeats);
        int nwr;
        bit err;
        int w;
        nwr = (nbeats < wr_len + 1) ? nbeats : wr_len + 1;
        err = burst_err(wr_len, wr_burst);
        for (int b = 0; b < nbeats; b++) begin
            WDATA = wdat[b]; WSTRB = wstb[b]; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            #1;
            check_eq("wready", 64'(WREADY), 64'd1);
            @(posedge clock);
            @(negedge clock);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (!err) begin
            for (int b = 0; b < nwr; b++) begin
                w = beat_word(wr_idx, wr_len, wr_burst, b);
                for (int k = 0; k < 4; k++)
                    if (wstb[b][k]) m_mem[w][k*8 +: 8] = wdat[b][k*8 +: 8];
            end
        end
        check_eq("bvalid", 64'(BVALID), 64'd1);
        check_eq("bid", 64'(BID), 64'(wr_id));
        check_eq("bresp", 64'(BRESP), (err || nbeats != wr_len + 1) ? 64'd2 : 64'd0);
        BREADY = 1'b1;
        @(posedge clock);
        @(negedge clock);
        BREADY = 1'b0;
        check_eq("bvalid_clr", 64'(BVALID), 64'd0);
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int burst);
        int cnt = 0;
        ARID = id; ARADDR = addr; ARLEN = LW'(len); ARBURST = 2'(burst); ARVALID = 1'b1;
        rd_id = id; rd_idx = int'(addr) >> 2; rd_len = len; rd_burst = burst;
        #1;
        while (!ARREADY && cnt < 50) begin
            @(negedge clock); #1; cnt++;
        end
        if (!ARREADY) check_eq("ar_handshake", 64'(ARREADY), 64'd1);
        @(posedge clock);
        @(negedge clock);
        ARVALID = 1'b0;
    endtask

    // Accepts up to ntake beats; stalls RREADY for stall_n cycles on beat stall_beat
    task automatic recv_r(input int ntake, input int stall_beat, input int stall_n);
        bit            err;
        logic [DW-1:0] exp;
        err = burst_err(rd_len, rd_burst);
        for (int b = 0; b <= rd_len && b < ntake; b++) begin
            exp = err ? '0 : m_mem[beat_word(rd_idx, rd_len, rd_burst, b)];
            check_eq("rvalid", 64'(RVALID), 64'd1);
            check_eq("rid", 64'(RID), 64'(rd_id));
            check_eq("rdata", 64'(RDATA), 64'(exp));
            check_eq("rresp", 64'(RRESP), err ? 64'd2 : 64'd0);
            check_eq("rlast", 64'(RLAST), 64'(b == rd_len));
            if (b == stall_beat) begin
                repeat (stall_n) begin
                    @(negedge clock);
                    check_eq("stall_rvalid", 64'(RVALID), 64'd1);
                    check_eq("stall_rdata", 64'(RDATA), 64'(exp));
                    check_eq("stall_rlast", 64'(RLAST), 64'(b == rd_len));
                end
            end
            RREADY = 1'b1;
            @(posedge clock);
            @(negedge clock);
            RREADY = 1'b0;
        end
        if (ntake > rd_len) check_eq("rvalid_clr", 64'(RVALID), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst, len, start, nb, r, sb;
        logic [IW-1:0] id;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        for (int i = 0; i < 24; i++) begin wdat[i] = '0; wstb[i] = 4'hF; end
        for (int i = 0; i < int'(NW); i++) m_mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_arready", 64'(ARREADY), 64'd0);
        check_eq("rst_awready", 64'(AWREADY), 64'd0);
        check_eq("rst_wready", 64'(WREADY), 64'd0);
        check_eq("rst_rvalid", 64'(RVALID), 64'd0);
        check_eq("rst_rlast", 64'(RLAST), 64'd0);
        check_eq("rst_bvalid", 64'(BVALID), 64'd0);
        check_eq("rst_rdata", 64'(RDATA), 64'd0);
        check_eq("rst_rid", 64'(RID), 64'd0);
        check_eq("rst_bid", 64'(BID), 64'd0);
        check_eq("rst_rresp", 64'(RRESP), 64'd0);
        check_eq("rst_bresp", 64'(BRESP), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Fill words 0..63 so every later read has a defined value
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            send_aw(8'(c), AW'(c * 64), 15, 1);
            send_w_b(16);
        end

        // Fresh reset restores write-first priority; memory keeps its contents
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Round 1: simultaneous requests, write wins
        ARID = 8'hA5; ARADDR = 16'h0010; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        AWID = 8'h5A; AWADDR = 16'h0010; AWLEN = 4'd3; AWBURST = 2'b01; AWVALID = 1'b1;
        #1;
        check_eq("arb1_awready", 64'(AWREADY), 64'd1);
        check_eq("arb1_arready", 64'(ARREADY), 64'd0);
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA000_0000 + 32'(i); wstb[i] = 4'hF; end
        send_aw(8'h5A, 16'h0010, 3, 1);
        send_w_b(4);
        send_ar(8'hA5, 16'h0010, 3, 1);
        recv_r(4, -1, 0);

        // Round 2: simultaneous requests, read wins this time
        ARID = 8'h33; ARADDR = 16'h0010; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        AWID = 8'h44; AWADDR = 16'h0018; AWLEN = 4'd3; AWBURST = 2'b10; AWVALID = 1'b1;
        #1;
        check_eq("arb2_arready", 64'(ARREADY), 64'd1);
        check_eq("arb2_awready", 64'(AWREADY), 64'd0);
        send_ar(8'h33, 16'h0010, 3, 1);
        recv_r(4, -1, 0);
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hD000_0000 + 32'(i); wstb[i] = 4'hF; end
        send_aw(8'h44, 16'h0018, 3, 2);
        send_w_b(4);
        check_eq("wrap_word6", 64'(m_mem[6]), 64'hD000_0000);
        check_eq("wrap_word4", 64'(m_mem[4]), 64'hD000_0002);

        // WRAP read returns D0..D3; WRAP with LEN=2 is an error burst
        send_ar(8'h10, 16'h0018, 3, 2);
        recv_r(4, -1, 0);
        send_ar(8'h11, 16'h0018, 2, 2);
        recv_r(3, -1, 0);

        // Byte strobe merge
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        send_aw(8'h20, 16'h0080, 0, 1);
        send_w_b(1);
        wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
        send_aw(8'h21, 16'h0080, 0, 1);
        send_w_b(1);
        check_eq("strb_model", 64'(m_mem[32]), 64'hAA22CC44);
        send_ar(8'h22, 16'h0080, 0, 1);
        recv_r(1, -1, 0);

        // FIXED burst: last beat survives
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        send_aw(8'h23, 16'h0000, 3, 0);
        send_w_b(4);
        send_ar(8'h24, 16'h0000, 0, 1);
        recv_r(1, -1, 0);

        // Backpressure: RREADY low for 3 cycles on beat 2
        send_ar(8'h25, 16'h0010, 3, 1);
        recv_r(4, 1, 3);

        // Early WLAST on beat 2 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        send_aw(8'h26, 16'h0030, 3, 1);
        send_w_b(2);
        send_ar(8'h27, 16'h0030, 3, 1);
        recv_r(4, -1, 0);

        // Reserved burst type: no memory update
        send_aw(8'h28, 16'h0040, 1, 3);
        send_w_b(2);
        send_ar(8'h29, 16'h0040, 1, 1);
        recv_r(2, -1, 0);

        // WLAST missing on beat LEN+1: extra beats are discarded
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        send_aw(8'h2A, 16'h0050, 1, 1);
        send_w_b(4);
        send_ar(8'h2B, 16'h0050, 3, 1);
        recv_r(4, -1, 0);

        // Reset in the middle of a read burst
        send_ar(8'h3C, 16'h0040, 7, 1);
        recv_r(2, -1, 0);
        #2 reset = 1'b0;
        #1;
        check_eq("rstmid_rvalid", 64'(RVALID), 64'd0);
        check_eq("rstmid_rlast", 64'(RLAST), 64'd0);
        check_eq("rstmid_rdata", 64'(RDATA), 64'd0);
        RREADY = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rstmid_no_beats", 64'(RVALID), 64'd0);
        RREADY = 1'b0;
        send_ar(8'h3D, 16'h0040, 3, 1);
        recv_r(4, -1, 0);

        // Randomized write/read pairs
        for (int it = 0; it < 40; it++) begin
            burst = int'($urandom_range(0, 3));
            len   = int'($urandom_range(0, 7));
            if (burst == 2 && $urandom_range(0, 3) != 0) len = (1 << $urandom_range(1, 3)) - 1;
            start = int'($urandom_range(0, 47));
            nb    = len + 1;
            r     = int'($urandom_range(0, 7));
            if (r == 0) nb = len + 1 + int'($urandom_range(1, 3));
            else if (r == 1 && len > 0) nb = int'($urandom_range(1, len));
            for (int i = 0; i < 24; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
            id = 8'($urandom);
            send_aw(id, AW'(start * 4 + int'($urandom_range(0, 3))), len, burst);
            send_w_b(nb);
            if ($urandom_range(0, 1) == 1) begin
                burst = int'($urandom_range(0, 3));
                len   = int'($urandom_range(0, 7));
                start = int'($urandom_range(0, 47));
            end
            sb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1;
            send_ar(8'($urandom), AW'(start * 4), len, burst);
            recv_r(len + 1, sb, int'($urandom_range(1, 2)));
        end

        check_eq("ready_exclusive", 64'(n_both), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
